// File: rtl/st_packet_channel_arbiter.sv
// st_packet_channel_arbiter: packet-granular round-robin arbiter onto one channelized Avalon-ST byte stream.
module st_packet_channel_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     sop_error
);
    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     rr_ptr, rr_n, owner, owner_n, grant, cand;
    logic              has_grant, load, xfer, beat_sop, beat_eop;
    logic [DATA_W-1:0] beat_data;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return (p == IW'(NUM_IN - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan downward so the source closest to rr_ptr is written last and wins.
    always_comb begin
        grant     = owner;
        has_grant = (state == LOCKED);
        cand      = '0;
        if (state == IDLE) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                cand = IW'((int'(rr_ptr) + i) % NUM_IN);
                if (in_valid[cand]) begin
                    grant     = cand;
                    has_grant = 1'b1;
                end
            end
        end
    end

    assign load      = out_ready | ~out_valid;
    assign in_ready  = (has_grant & load) ? (NUM_IN'(1) << grant) : '0;
    assign xfer      = in_valid[grant] & in_ready[grant];
    assign beat_data = in_data[grant*DATA_W +: DATA_W];
    assign beat_sop  = in_startofpacket[grant];
    assign beat_eop  = in_endofpacket[grant];

    // In LOCKED grant equals owner, so one rule covers both states.
    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr_ptr;
        if (xfer) begin
            if (beat_eop) begin
                state_n = IDLE;
                rr_n    = nxt(grant);
            end else if (state == IDLE) begin
                state_n = LOCKED;
                owner_n = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= '0;
            sop_error         <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            owner     <= owner_n;
            sop_error <= xfer & (state == IDLE) & ~beat_sop;
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data          <= beat_data;
                    out_startofpacket <= beat_sop;
                    out_endofpacket   <= beat_eop;
                    out_channel       <= CHANNEL_W'(grant);
                end
            end
        end
    end
endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// tb_st_packet_channel_arbiter: directed vectors with hand-computed expectations for the packet arbiter.
module tb_st_packet_channel_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_sop = '0;
    logic [3:0]  in_eop = '0;
    logic [3:0]  in_ready;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_channel;
    logic        sop_error;
    int          n_checks = 0;
    int          n_errors = 0;

    st_packet_channel_arbiter #(.NUM_IN(4), .DATA_W(8), .CHANNEL_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .out_channel(out_channel), .sop_error(sop_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic v, input logic [7:0] d, input logic s, input logic e);
        in_valid[k]       = v;
        in_data[k*8 +: 8] = d;
        in_sop[k]         = s;
        in_eop[k]         = e;
    endtask

    task automatic clear_all();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
    endtask

    task automatic rdy(input string tag, input logic [3:0] exp);
        #1;
        check(tag, 32'(in_ready), 32'(exp));
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic s, input logic e, input logic [7:0] ch);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".sop"}, 32'(out_sop), 32'(s));
        check({tag, ".eop"}, 32'(out_eop), 32'(e));
        check({tag, ".chan"}, 32'(out_channel), 32'(ch));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.chan", 32'(out_channel), 32'd0);
        check("rst.sop_err", 32'(sop_error), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd0);

        set_src(2, 1, 8'hA1, 1, 0); rdy("t1.rdy0", 4'b0100);
        cyc(); beat("t1.b1", 8'hA1, 1, 0, 8'd2);
        set_src(2, 1, 8'hA2, 0, 0);
        cyc(); beat("t1.b2", 8'hA2, 0, 0, 8'd2);
        set_src(2, 1, 8'hA3, 0, 1);
        cyc(); beat("t1.b3", 8'hA3, 0, 1, 8'd2);
        clear_all();
        set_src(0, 1, 8'h30, 1, 1);
        set_src(3, 1, 8'h33, 1, 1); rdy("t1.rr3", 4'b1000);
        cyc(); beat("t1.s3", 8'h33, 1, 1, 8'd3);
        set_src(3, 0, 8'h33, 1, 1); rdy("t1.rr0", 4'b0001);
        cyc(); beat("t1.s0", 8'h30, 1, 1, 8'd0);
        clear_all();
        cyc(); check("t1.idle", 32'(out_valid), 32'd0);

        do_reset();
        set_src(0, 1, 8'h01, 1, 0);
        set_src(1, 1, 8'h11, 1, 0); rdy("t2.rdy0", 4'b0001);
        cyc(); beat("t2.a1", 8'h01, 1, 0, 8'd0);
        set_src(0, 1, 8'h02, 0, 1); rdy("t2.rdy1", 4'b0001);
        cyc(); beat("t2.a2", 8'h02, 0, 1, 8'd0);
        set_src(0, 0, 8'h00, 0, 0); rdy("t2.rdy2", 4'b0010);
        cyc(); beat("t2.b1", 8'h11, 1, 0, 8'd1);
        set_src(1, 1, 8'h12, 0, 1);
        cyc(); beat("t2.b2", 8'h12, 0, 1, 8'd1);
        clear_all();

        set_src(1, 1, 8'h21, 1, 0); rdy("t3.rdy0", 4'b0010);
        cyc(); beat("t3.a1", 8'h21, 1, 0, 8'd1);
        set_src(1, 0, 8'h00, 0, 0);
        set_src(3, 1, 8'h41, 1, 1); rdy("t3.lock", 4'b0010);
        cyc(); check("t3.gap", 32'(out_valid), 32'd0);
        set_src(1, 1, 8'h22, 0, 1); rdy("t3.rdy2", 4'b0010);
        cyc(); beat("t3.a2", 8'h22, 0, 1, 8'd1);
        set_src(1, 0, 8'h00, 0, 0); rdy("t3.rdy3", 4'b1000);
        cyc(); beat("t3.b", 8'h41, 1, 1, 8'd3);
        clear_all();

        set_src(0, 1, 8'hB1, 1, 0);
        cyc(); beat("t4.b1", 8'hB1, 1, 0, 8'd0);
        out_ready = 1'b0;
        set_src(0, 1, 8'hB2, 0, 0); rdy("t4.stall1", 4'b0000);
        cyc(); beat("t4.hold1", 8'hB1, 1, 0, 8'd0);
        rdy("t4.stall2", 4'b0000);
        cyc(); beat("t4.hold2", 8'hB1, 1, 0, 8'd0);
        out_ready = 1'b1; rdy("t4.resume", 4'b0001);
        cyc(); beat("t4.b2", 8'hB2, 0, 0, 8'd0);
        set_src(0, 1, 8'hB3, 0, 0);
        cyc(); beat("t4.b3", 8'hB3, 0, 0, 8'd0);
        set_src(0, 1, 8'hB4, 0, 1);
        cyc(); beat("t4.b4", 8'hB4, 0, 1, 8'd0);
        clear_all();

        do_reset();
        for (int k = 0; k < 4; k++) set_src(k, 1, 8'(8'hC0 + k), 1, 1);
        for (int n = 0; n < 5; n++) begin
            rdy($sformatf("t5.rdy%0d", n), 4'(1 << (n % 4)));
            cyc();
            beat($sformatf("t5.s%0d", n), 8'(8'hC0 + n % 4), 1, 1, 8'(n % 4));
        end
        clear_all();

        set_src(2, 1, 8'hD1, 0, 0); rdy("t6.rdy", 4'b0100);
        cyc(); beat("t6.d1", 8'hD1, 0, 0, 8'd2);
        check("t6.err_on", 32'(sop_error), 32'd1);
        set_src(2, 1, 8'hD2, 0, 0);
        cyc(); beat("t6.d2", 8'hD2, 0, 0, 8'd2);
        check("t6.err_off", 32'(sop_error), 32'd0);
        reset = 1'b1;
        set_src(2, 1, 8'hD3, 0, 0);
        cyc();
        reset = 1'b0;
        check("t6.rst_valid", 32'(out_valid), 32'd0);
        check("t6.rst_err", 32'(sop_error), 32'd0);
        set_src(0, 1, 8'hE0, 1, 1); rdy("t6.unlock", 4'b0001);
        cyc(); beat("t6.e0", 8'hE0, 1, 1, 8'd0);
        clear_all();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/st_packet_channel_arbiter.md
Name: st_packet_channel_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one channelized Avalon-ST byte stream between NUM_IN packet sources.
- Output feeds the packets-to-bytes channel path in the debug-master chain.
- Grant is held from the first beat to the EOP beat. out_channel carries the granted source index.
- One registered output stage gives 1-cycle latency under full ready/valid backpressure.

Parameters:
- NUM_IN, 4, number of requesting sources (2..8).
- DATA_W, 8, symbol width per beat.
- CHANNEL_W, 8, width of out_channel (must be >= clog2(NUM_IN)).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_IN  per-source valid.
- in_data  input  NUM_IN*DATA_W  per-source data; source k at bits [k*DATA_W +: DATA_W].
- in_startofpacket  input  NUM_IN  per-source SOP.
- in_endofpacket  input  NUM_IN  per-source EOP.
- in_ready  output  NUM_IN  per-source ready (combinational).
- out_ready  input  1  downstream ready.
- out_valid  output  1  registered valid.
- out_data  output  DATA_W  registered data.
- out_startofpacket  output  1  registered SOP.
- out_endofpacket  output  1  registered EOP.
- out_channel  output  CHANNEL_W  registered granted source index, zero-extended.
- sop_error  output  1  1-cycle pulse: packet started without SOP.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, sop_error=0, state=IDLE, rr_ptr=0.
- Reset mid-packet: the held beat and the lock are discarded; no partial packet is resumed.
- Accept condition: load = out_ready | ~out_valid.
- Transfer from source k: in_valid[k] & in_ready[k]. Every other in_ready bit is 0.
- in_ready[k] = load & (k == current grant). The data of the transferring beat appears on out_* the next cycle (latency 1).
- Output register: if load, it captures the granted beat (out_valid=1) when a transfer occurs, else sets out_valid=0. If ~load, all out_* hold.
- State IDLE (no owner):
  - Combinational grant = first k with in_valid[k] = 1, scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
  - Arbitration is zero-bubble: the winner's first beat may transfer in the same cycle.
  - No valid input: no grant, in_ready=0.
- IDLE transitions:
  - Transfer of a non-EOP beat -> LOCKED, owner = grant.
  - Transfer of an SOP&EOP beat (single-beat packet) -> stay IDLE, rr_ptr = grant+1 mod NUM_IN.
  - If the transferred first beat has SOP=0, pulse sop_error the next cycle. The beat is still forwarded with out_startofpacket=0, and the lock proceeds normally.
- State LOCKED:
  - grant = owner. Other sources are ignored even if valid.
  - Owner idle (in_valid=0) keeps the lock; no timeout.
  - Transfer of an EOP beat -> IDLE, rr_ptr = owner+1 mod NUM_IN. The next packet can be granted the following cycle (no dead cycle beyond the IDLE evaluation).
  - SOP seen mid-packet is forwarded unchanged; it does not restart the arbitration.
- out_ready low with a held beat: in_ready=0 for all sources; state and grant are frozen.
- out_channel = grant index, upper bits 0.
- rr_ptr wraps from NUM_IN-1 to 0.
- Simultaneous requests are resolved purely by rr_ptr order. A source losing arbitration is never starved longer than NUM_IN-1 packets.

Test Plan:
- Reset, then src2 sends 3-beat packet 0xA1,0xA2,0xA3 (SOP on first, EOP on last), out_ready=1 -> out_data A1,A2,A3 on cycles t+1..t+3; out_channel=2; SOP/EOP align; rr_ptr becomes 3.
- src0 and src1 both valid with 2-beat packets from reset -> src0 packet fully first (channel 0), then src1 (channel 1) starting the cycle after src0's EOP transfer; no interleaving.
- src1 mid-packet and src3 asserts valid -> src3 in_ready stays 0 until src1 EOP accepted; src3 then granted with no extra idle cycle.
- out_ready toggles 1,0,0,1 during src0 4-beat packet -> out_* holds while out_ready=0, no beat lost or duplicated, in_ready[0]=0 during stall.
- Single-beat packets (SOP&EOP) continuously from all 4 sources -> out_channel sequence 0,1,2,3,0,... one beat per cycle.
- src2 first beat with SOP=0 -> sop_error=1 for exactly one cycle, packet still forwarded. Then assert reset mid-packet -> out_valid=0 next cycle, state IDLE, rr_ptr=0.
